// File: rtl/secded_pkg.sv
// Shared SECDED (15,11 + overall parity) types, flag codes and codeword helpers.
package secded_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [1:0] FLG_NONE = 2'b00;
    localparam logic [1:0] FLG_SGL  = 2'b01;
    localparam logic [1:0] FLG_DBL  = 2'b10;

    // XOR of the positions 1..15 whose bit is set; zero for a valid codeword.
    function automatic logic [3:0] secded_syndrome(input logic [15:0] r);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p < 16; p++) begin
            if (r[p]) begin
                s = s ^ 4'(p);
            end
        end
        return s;
    endfunction

    function automatic logic [15:0] secded_encode(input logic [11:1] d);
        logic [15:0] r;
        logic [3:0]  s;
        r        = 16'd0;
        r[3]     = d[1];
        r[7:5]   = d[4:2];
        r[15:9]  = d[11:5];
        s        = secded_syndrome(r);
        r[1]     = s[0];
        r[2]     = s[1];
        r[4]     = s[2];
        r[8]     = s[3];
        r[0]     = ^r[15:1];
        return r;
    endfunction

endpackage

// File: rtl/secded_dec16.sv
// SECDED decode of one 16-bit word into 11 data bits and a status flag.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module secded_dec16
    import secded_pkg::*;
(
    input  logic [15:0] r,
    output logic [11:1] data,
    output logic [1:0]  flag
);

    logic [3:0]  syn;
    logic        par;
    logic [15:0] fixed;

    always_comb begin
        syn   = secded_syndrome(r);
        par   = ^r;
        fixed = r;
        flag  = FLG_NONE;
        if (par) begin
            // s==0 flips the overall parity bit only, leaving data untouched
            flag  = FLG_SGL;
            fixed = r ^ (16'd1 << syn);
        end else if (syn != 4'd0) begin
            flag = FLG_DBL;
        end
        data = {fixed[15:9], fixed[7:5], fixed[3]};
    end

endmodule

// File: rtl/secded_dec_seq.sv
// Memory-port sequencer: reads NUM_WORDS SECDED words, writes decoded data+flag back.
// Latency: 4 cycles per word, done in cycle 4*NUM_WORDS+1 after start.
// Backpressure: none; memory is assumed single-cycle, start ignored while busy.
module secded_dec_seq
    import secded_pkg::*;
#(
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int NUM_WORDS = 15,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] dm_addr,
    input  logic [7:0]    dm_rd_data,
    output logic          dm_wr_en,
    output logic [7:0]    dm_wr_data,
    output logic          busy,
    output logic          done,
    output logic [7:0]    single_cnt,
    output logic [7:0]    double_cnt
);

    localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [6:0]    idx;
    logic [7:0]    lo;
    logic [7:0]    hi;
    logic [11:1]   dec_data;
    logic [1:0]    dec_flag;
    logic [15:0]   result;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          last_word;

    secded_dec16 u_dec (
        .r    ({hi, lo}),
        .data (dec_data),
        .flag (dec_flag)
    );

    assign result    = {dec_flag, 3'b000, dec_data};
    assign src_addr  = AW'(SRC_BASE) + AW'({idx, 1'b0});
    assign dst_addr  = AW'(DST_BASE) + AW'({idx, 1'b0});
    assign last_word = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 7'd0;
            lo         <= 8'd0;
            hi         <= 8'd0;
            single_cnt <= 8'd0;
            double_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= 7'd0;
                        single_cnt <= 8'd0;
                        double_cnt <= 8'd0;
                    end
                end
                RD_LO: lo <= dm_rd_data;
                RD_HI: hi <= dm_rd_data;
                WR_LO: begin
                    if (dec_flag == FLG_SGL && single_cnt != 8'hFF) begin
                        single_cnt <= single_cnt + 8'd1;
                    end
                    if (dec_flag == FLG_DBL && double_cnt != 8'hFF) begin
                        double_cnt <= double_cnt + 8'd1;
                    end
                end
                WR_HI: begin
                    if (!last_word) begin
                        idx <= idx + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        dm_addr    = '0;
        dm_wr_en   = 1'b0;
        dm_wr_data = 8'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RD_LO;
            end
            RD_LO: begin
                busy      = 1'b1;
                dm_addr   = src_addr;
                state_nxt = RD_HI;
            end
            RD_HI: begin
                busy      = 1'b1;
                dm_addr   = src_addr + AW'(1);
                state_nxt = WR_LO;
            end
            WR_LO: begin
                busy       = 1'b1;
                dm_addr    = dst_addr;
                dm_wr_en   = ~reset;
                dm_wr_data = result[7:0];
                state_nxt  = WR_HI;
            end
            WR_HI: begin
                busy       = 1'b1;
                dm_addr    = dst_addr + AW'(1);
                dm_wr_en   = ~reset;
                dm_wr_data = result[15:8];
                state_nxt  = last_word ? DONE : RD_LO;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RD_LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_secded_dec_seq.sv
// Randomized scoreboard bench for secded_dec_seq against a brute-force SECDED reference.
module tb_secded_dec_seq;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dm_addr;
    logic [7:0] dm_rd_data;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;
    logic       busy;
    logic       done;
    logic [7:0] single_cnt;
    logic [7:0] double_cnt;

    secded_dec_seq #(
        .SRC_BASE  (SRC),
        .DST_BASE  (DST),
        .NUM_WORDS (NW),
        .AW        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .dm_wr_en   (dm_wr_en),
        .dm_wr_data (dm_wr_data),
        .busy       (busy),
        .done       (done),
        .single_cnt (single_cnt),
        .double_cnt (double_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:255];
    logic [7:0] ram [0:255];
    assign dm_rd_data = rom[dm_addr];
    always @(posedge clk) if (dm_wr_en) ram[dm_addr] <= dm_wr_data;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] words [0:NW-1];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_sgl;
    int          exp_dbl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Data occupies the non-power-of-two positions 3..15 in ascending order;
    // parity bits at 1,2,4,8 are chosen so the XOR of all set positions is zero.
    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] r;
        logic [3:0]  s;
        int          k;
        r = 16'd0;
        k = 0;
        for (int p = 3; p < 16; p++) begin
            if (p != 4 && p != 8) begin
                r[p] = d[k];
                k++;
            end
        end
        s = 4'd0;
        for (int p = 1; p < 16; p++) if (r[p]) s = s ^ 4'(p);
        for (int b = 0; b < 4; b++) r[1 << b] = s[b];
        r[0] = ^r;
        return r;
    endfunction

    function automatic logic [10:0] ref_extract(input logic [15:0] r);
        logic [10:0] d;
        int          k;
        d = 11'd0;
        k = 0;
        for (int p = 3; p < 16; p++) begin
            if (p != 4 && p != 8) begin
                d[k] = r[p];
                k++;
            end
        end
        return d;
    endfunction

    // Classify by distance to the nearest valid codeword.
    function automatic logic [15:0] ref_result(input logic [15:0] w);
        logic [15:0] t;
        if (ref_encode(ref_extract(w)) == w) return {5'b00000, ref_extract(w)};
        for (int b = 0; b < 16; b++) begin
            t = w ^ (16'd1 << b);
            if (ref_encode(ref_extract(t)) == t) return {5'b01000, ref_extract(t)};
        end
        return {5'b10000, ref_extract(w)};
    endfunction

    task automatic gen_words(input bit directed);
        exp_sgl = 0;
        exp_dbl = 0;
        for (int i = 0; i < NW; i++) begin
            logic [10:0] d;
            logic [15:0] w;
            int          ne;
            int          b1;
            int          b2;
            d  = 11'($urandom_range(0, 2047));
            ne = int'($urandom_range(0, 2));
            b1 = int'($urandom_range(0, 15));
            b2 = (b1 + 1 + int'($urandom_range(0, 14))) % 16;
            if (directed && i < 4) begin
                d  = 11'h5A3;
                ne = (i == 0) ? 0 : (i == 3) ? 2 : 1;
                b1 = (i == 2) ? 0 : (i == 3) ? 3 : 6;
                b2 = 12;
            end
            w = ref_encode(d);
            if (ne >= 1) w[b1] = ~w[b1];
            if (ne == 2) w[b2] = ~w[b2];
            words[i]         = w;
            rom[SRC + 2*i]   = w[7:0];
            rom[SRC + 2*i+1] = w[15:8];
            if (ne == 1) exp_sgl++;
            if (ne == 2) exp_dbl++;
        end
    endtask

    task automatic push_exp(input int n);
        logic [15:0] res;
        for (int i = 0; i < n; i++) begin
            res = ref_result(words[i]);
            exp_q.push_back('{8'(DST + 2*i), res[7:0]});
            exp_q.push_back('{8'(DST + 2*i + 1), res[15:8]});
        end
    endtask

    // Scoreboard monitor: every DUT write must match the next expected write.
    always @(negedge clk) begin
        if (dm_wr_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write", dm_addr, dm_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(dm_addr), 32'(e.addr));
                check("wr_data", 32'(dm_wr_data), 32'(e.data));
            end
        end
    end

    // Pulses start for one edge, then counts cycles until done is seen.
    task automatic run(input bit pulse_busy, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("start_busy", 32'(busy), 32'd1);
                check("start_done_low", 32'(done), 32'd0);
                check("start_sgl_clr", 32'(single_cnt), 32'd0);
                check("start_dbl_clr", 32'(double_cnt), 32'd0);
            end
            start = pulse_busy && (cyc == 10);
            if (done) break;
        end
        start = 1'b0;
    endtask

    int cyc;

    initial begin
        for (int a = 0; a < 256; a++) begin
            rom[a] = 8'd0;
            ram[a] = 8'd0;
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(dm_wr_en), 32'd0);
        check("rst_addr", 32'(dm_addr), 32'd0);
        check("rst_wr_data", 32'(dm_wr_data), 32'd0);
        check("rst_sgl", 32'(single_cnt), 32'd0);
        check("rst_dbl", 32'(double_cnt), 32'd0);
        reset = 1'b0;

        // Directed words first, with a start pulse mid-run that must be ignored.
        gen_words(1'b1);
        push_exp(NW);
        run(1'b1, cyc);
        check("run1_done_cycle", 32'(cyc), 32'd61);
        check("run1_sgl", 32'(single_cnt), 32'(exp_sgl));
        check("run1_dbl", 32'(double_cnt), 32'(exp_dbl));
        check("run1_q_empty", 32'(exp_q.size()), 32'd0);
        check("clean_word", {16'd0, ram[1], ram[0]}, 32'h05A3);
        check("sgl_bit6", {16'd0, ram[3], ram[2]}, 32'h45A3);
        check("sgl_bit0", {16'd0, ram[5], ram[4]}, 32'h45A3);
        check("dbl_flag", 32'(ram[7][7:6]), 32'd2);
        @(negedge clk);
        check("done_hold", 32'(done), 32'd1);

        // Restart straight from DONE with fresh random words.
        gen_words(1'b0);
        push_exp(NW);
        run(1'b0, cyc);
        check("run2_done_cycle", 32'(cyc), 32'd61);
        check("run2_sgl", 32'(single_cnt), 32'(exp_sgl));
        check("run2_dbl", 32'(double_cnt), 32'(exp_dbl));
        check("run2_q_empty", 32'(exp_q.size()), 32'd0);

        // Abort during word 5: only words 0..4 may be written.
        gen_words(1'b0);
        push_exp(5);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 22; c++) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sgl", 32'(single_cnt), 32'd0);
        check("abort_dbl", 32'(double_cnt), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        check("abort_idle", 32'(busy | done), 32'd0);

        gen_words(1'b0);
        push_exp(NW);
        run(1'b0, cyc);
        check("run3_done_cycle", 32'(cyc), 32'd61);
        check("run3_sgl", 32'(single_cnt), 32'(exp_sgl));
        check("run3_dbl", 32'(double_cnt), 32'(exp_dbl));
        check("run3_q_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
